hazard_ctrl_unit: RTL and testbench

Pipeline hazard controller for the 5-stage core. It sits directly downstream of the forwarding unit: it consumes the forwarding unit's load-use Need_Stall, the EX-stage branch resolution and the data-memory busy flag. From these it drives the write-enable and flush (bubble) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small FSM guarantees single-bubble load-use stalls and masks spurious stalls in branch shadows.

---
 rtl/hcu_pkg.sv | 30 +++
 rtl/hazard_ctrl_unit_if.sv | 31 +++
 rtl/hcu_wait_counter.sv | 37 +++
 rtl/hazard_ctrl_unit.sv | 109 ++++++++++
 tb/tb_hazard_ctrl_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/hcu_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and the
// bundle of per-register write-enable/flush controls.
package hcu_pkg;

    localparam int HCU_STATE_W = 2;

    typedef enum logic [HCU_STATE_W-1:0] {
        HCU_RUN       = 2'b00,
        HCU_LU_STALL  = 2'b01,
        HCU_BR_SHADOW = 2'b10,
        HCU_MEM_WAIT  = 2'b11
    } hcu_state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic memwb_flush;
    } hcu_ctrl_t;

    // Control patterns; any asserted flush keeps its register's WE high.
    localparam hcu_ctrl_t HCU_CTRL_RUN    = hcu_ctrl_t'(7'b1101010);
    localparam hcu_ctrl_t HCU_CTRL_HOLD   = hcu_ctrl_t'(7'b0000001);
    localparam hcu_ctrl_t HCU_CTRL_BRANCH = hcu_ctrl_t'(7'b1111110);
    localparam hcu_ctrl_t HCU_CTRL_STALL  = hcu_ctrl_t'(7'b0001110);

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard inputs from the core and pipeline-register controls back to it.
// master = core side, slave = hazard controller.
interface hazard_ctrl_unit_if;
    import hcu_pkg::*;

    logic                   FU__Need_Stall;
    logic                   EX__Branch_Taken;
    logic                   MEM__Busy;
    logic                   PC_WE;
    logic                   IFid_WE;
    logic                   IFid_Flush;
    logic                   IDex_WE;
    logic                   IDex_Flush;
    logic                   EXmem_WE;
    logic                   MEMwb_Flush;
    logic                   Mem_Timeout;
    logic [HCU_STATE_W-1:0] HCU_State;

    modport master (
        output FU__Need_Stall, EX__Branch_Taken, MEM__Busy,
        input  PC_WE, IFid_WE, IFid_Flush, IDex_WE, IDex_Flush,
               EXmem_WE, MEMwb_Flush, Mem_Timeout, HCU_State
    );

    modport slave (
        input  FU__Need_Stall, EX__Branch_Taken, MEM__Busy,
        output PC_WE, IFid_WE, IFid_Flush, IDex_WE, IDex_Flush,
               EXmem_WE, MEMwb_Flush, Mem_Timeout, HCU_State
    );

endinterface

// File: rtl/hcu_wait_counter.sv
// Counts consecutive memory-busy cycles, saturating at MEM_WAIT_MAX, and
// raises a sticky timeout on the edge the count reaches MEM_WAIT_MAX.
module hcu_wait_counter #(
    parameter int MEMWAIT_W    = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_busy,
    output logic o_timeout
);
    import hcu_pkg::*;

    localparam logic [MEMWAIT_W-1:0] MAXV = MEM_WAIT_MAX[MEMWAIT_W-1:0];

    logic [MEMWAIT_W-1:0] r_count;
    logic [MEMWAIT_W-1:0] w_count_nxt;
    logic                 r_timeout;

    assign w_count_nxt = (r_count == MAXV) ? MAXV : r_count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else if (i_busy) begin
            r_count <= w_count_nxt;
            if (w_count_nxt == MAXV)
                r_timeout <= 1'b1;
        end else begin
            r_count <= '0;
        end
    end

    assign o_timeout = r_timeout;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: turns load-use, branch and memory-busy events
// into PC / pipeline-register WE and flush controls. Optional macro
// HCU_PERF_CNT_EN adds stall/flush/mem-wait performance counters.
module hazard_ctrl_unit
    import hcu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int MEMWAIT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    hazard_ctrl_unit_if.slave  bus
`ifdef HCU_PERF_CNT_EN
    ,
    output logic [31:0]        Perf_Stall_Cnt,
    output logic [31:0]        Perf_Flush_Cnt,
    output logic [31:0]        Perf_MemWait_Cnt
`endif
);

    hcu_state_e r_state;
    hcu_state_e w_next_state;
    hcu_ctrl_t  w_ctrl;
    logic       w_stall_ok;
    logic       w_lu_ev;
    logic       w_br_ev;
    logic       w_busy_ev;
    logic       w_timeout;

    // Stall is honoured only where ID/EX can hold a live consumer; after a
    // bubble or a squash it is masked so each load-use costs one bubble.
    assign w_stall_ok = (r_state == HCU_RUN) || (r_state == HCU_MEM_WAIT);

    always_comb begin
        w_ctrl       = HCU_CTRL_RUN;
        w_next_state = HCU_RUN;
        w_lu_ev      = 1'b0;
        w_br_ev      = 1'b0;
        w_busy_ev    = 1'b0;
        if (!rst) begin
            if (bus.MEM__Busy) begin
                w_ctrl       = HCU_CTRL_HOLD;
                w_next_state = HCU_MEM_WAIT;
                w_busy_ev    = 1'b1;
            end else if (bus.EX__Branch_Taken) begin
                w_ctrl       = HCU_CTRL_BRANCH;
                w_next_state = HCU_BR_SHADOW;
                w_br_ev      = 1'b1;
            end else if (bus.FU__Need_Stall && w_stall_ok) begin
                w_ctrl       = HCU_CTRL_STALL;
                w_next_state = HCU_LU_STALL;
                w_lu_ev      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= HCU_RUN;
        else
            r_state <= w_next_state;
    end

    hcu_wait_counter #(
        .MEMWAIT_W    (MEMWAIT_W),
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_wait_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_busy    (bus.MEM__Busy),
        .o_timeout (w_timeout)
    );

    assign bus.PC_WE       = w_ctrl.pc_we;
    assign bus.IFid_WE     = w_ctrl.ifid_we;
    assign bus.IFid_Flush  = w_ctrl.ifid_flush;
    assign bus.IDex_WE     = w_ctrl.idex_we;
    assign bus.IDex_Flush  = w_ctrl.idex_flush;
    assign bus.EXmem_WE    = w_ctrl.exmem_we;
    assign bus.MEMwb_Flush = w_ctrl.memwb_flush;
    assign bus.Mem_Timeout = w_timeout;
    assign bus.HCU_State   = r_state;

`ifdef HCU_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_memwait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_memwait_cnt <= '0;
        end else begin
            if (w_lu_ev)   r_stall_cnt   <= r_stall_cnt + 32'd1;
            if (w_br_ev)   r_flush_cnt   <= r_flush_cnt + 32'd1;
            if (w_busy_ev) r_memwait_cnt <= r_memwait_cnt + 32'd1;
        end
    end

    assign Perf_Stall_Cnt   = r_stall_cnt;
    assign Perf_Flush_Cnt   = r_flush_cnt;
    assign Perf_MemWait_Cnt = r_memwait_cnt;
`else
    logic w_unused_ev;
    assign w_unused_ev = w_lu_ev ^ w_br_ev ^ w_busy_ev;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus a random
// run scored against an event-history reference model.
module tb_hazard_ctrl_unit;

    localparam int MAX = 15;
    // Control vector order: PC_WE IFid_WE IFid_Flush IDex_WE IDex_Flush EXmem_WE MEMwb_Flush
    localparam logic [6:0] C_RUN = 7'b1101010;
    localparam logic [6:0] C_HLD = 7'b0000001;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_LU  = 7'b0001110;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if bus();

`ifdef HCU_PERF_CNT_EN
    logic [31:0] perf_stall, perf_flush, perf_mw;
`endif

    hazard_ctrl_unit #(.MEM_WAIT_MAX(MAX), .MEMWAIT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef HCU_PERF_CNT_EN
        ,
        .Perf_Stall_Cnt   (perf_stall),
        .Perf_Flush_Cnt   (perf_flush),
        .Perf_MemWait_Cnt (perf_mw)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: what happened on the previous cycle (0 none, 1 load-use bubble,
    // 2 branch squash, 3 memory hold), length of the current busy run,
    // sticky timeout, and event tallies.
    int m_prev = 0;
    int m_run  = 0;
    bit m_tmo  = 1'b0;
    int m_ps = 0, m_pf = 0, m_pm = 0;

    function automatic int event_now();
        if (rst) return 0;
        if (bus.MEM__Busy) return 3;
        if (bus.EX__Branch_Taken) return 2;
        // a stall right after a bubble or squash refers to the same consumer
        if (bus.FU__Need_Stall && m_prev != 1 && m_prev != 2) return 1;
        return 0;
    endfunction

    function automatic logic [6:0] exp_ctrl();
        case (event_now())
            1: return C_LU;
            2: return C_BR;
            3: return C_HLD;
            default: return C_RUN;
        endcase
    endfunction

    function automatic logic [6:0] act_ctrl();
        return {bus.PC_WE, bus.IFid_WE, bus.IFid_Flush, bus.IDex_WE,
                bus.IDex_Flush, bus.EXmem_WE, bus.MEMwb_Flush};
    endfunction

    function automatic logic [1:0] exp_state();
        case (m_prev)
            1: return 2'b01;
            2: return 2'b10;
            3: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic apply(input logic st, input logic br, input logic bz);
        bus.FU__Need_Stall   = st;
        bus.EX__Branch_Taken = br;
        bus.MEM__Busy        = bz;
        #1;
    endtask

    task automatic tick();
        int e;
        @(posedge clk);
        e = event_now();
        if (rst) begin
            m_prev = 0; m_run = 0; m_tmo = 1'b0;
            m_ps = 0; m_pf = 0; m_pm = 0;
        end else begin
            if (e == 1) m_ps++;
            if (e == 2) m_pf++;
            if (e == 3) m_pm++;
            m_prev = e;
            m_run  = bus.MEM__Busy ? m_run + 1 : 0;
            if (m_run >= MAX) m_tmo = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(1, 1, 1);
        n_chk++; if (act_ctrl() !== C_RUN) $display("FAIL reset_ctrl_during_rst got=%b exp=%b", act_ctrl(), C_RUN); else n_pass++;
        tick(); tick();
        rst = 1'b0;
        apply(0, 0, 0);
        n_chk++; if (bus.HCU_State !== 2'b00) $display("FAIL reset_state got=%b exp=00", bus.HCU_State); else n_pass++;
        n_chk++; if (bus.Mem_Timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", bus.Mem_Timeout); else n_pass++;
        n_chk++; if (act_ctrl() !== C_RUN) $display("FAIL reset_ctrl got=%b exp=%b", act_ctrl(), C_RUN); else n_pass++;
    endtask

    task automatic test_load_use();
        apply(1, 0, 0);
        n_chk++; if (act_ctrl() !== C_LU) $display("FAIL lu_c0_ctrl got=%b exp=%b", act_ctrl(), C_LU); else n_pass++;
        tick();
        apply(1, 0, 0);
        n_chk++; if (bus.HCU_State !== 2'b01) $display("FAIL lu_c1_state got=%b exp=01", bus.HCU_State); else n_pass++;
        n_chk++; if (act_ctrl() !== C_RUN) $display("FAIL lu_c1_masked got=%b exp=%b", act_ctrl(), C_RUN); else n_pass++;
        tick();
        apply(0, 0, 0);
        n_chk++; if (bus.HCU_State !== 2'b00) $display("FAIL lu_c2_state got=%b exp=00", bus.HCU_State); else n_pass++;
    endtask

    task automatic test_branch_stall();
        apply(1, 1, 0);
        n_chk++; if (act_ctrl() !== C_BR) $display("FAIL br_ctrl got=%b exp=%b", act_ctrl(), C_BR); else n_pass++;
        tick();
        apply(1, 0, 0);
        n_chk++; if (bus.HCU_State !== 2'b10) $display("FAIL br_shadow_state got=%b exp=10", bus.HCU_State); else n_pass++;
        n_chk++; if (act_ctrl() !== C_RUN) $display("FAIL br_shadow_masked got=%b exp=%b", act_ctrl(), C_RUN); else n_pass++;
        tick();
        apply(0, 1, 0);
        n_chk++; if (act_ctrl() !== C_BR) $display("FAIL br_again_ctrl got=%b exp=%b", act_ctrl(), C_BR); else n_pass++;
        tick();
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 3; c++) begin
            apply(0, c == 1, 1);
            n_chk++; if (act_ctrl() !== C_HLD) $display("FAIL mw_hold_c%0d got=%b exp=%b", c, act_ctrl(), C_HLD); else n_pass++;
            tick();
            n_chk++; if (bus.HCU_State !== 2'b11) $display("FAIL mw_state_c%0d got=%b exp=11", c, bus.HCU_State); else n_pass++;
        end
        apply(1, 0, 0);
        n_chk++; if (act_ctrl() !== C_LU) $display("FAIL mw_release_stall got=%b exp=%b", act_ctrl(), C_LU); else n_pass++;
        tick();
        apply(0, 0, 0);
        n_chk++; if (bus.HCU_State !== 2'b01) $display("FAIL mw_release_state got=%b exp=01", bus.HCU_State); else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        for (int c = 0; c < MAX - 1; c++) begin
            apply(0, 0, 1);
            tick();
        end
        n_chk++; if (bus.Mem_Timeout !== 1'b0) $display("FAIL tmo_early got=%b exp=0", bus.Mem_Timeout); else n_pass++;
        apply(0, 0, 1);
        tick();
        n_chk++; if (bus.Mem_Timeout !== 1'b1) $display("FAIL tmo_set got=%b exp=1", bus.Mem_Timeout); else n_pass++;
        apply(0, 0, 0);
        tick();
        n_chk++; if (bus.Mem_Timeout !== 1'b1) $display("FAIL tmo_sticky got=%b exp=1", bus.Mem_Timeout); else n_pass++;
        n_chk++; if (bus.HCU_State !== 2'b00) $display("FAIL tmo_run_state got=%b exp=00", bus.HCU_State); else n_pass++;
        rst = 1'b1;
        apply(0, 0, 1);
        tick();
        rst = 1'b0;
        apply(0, 0, 0);
        n_chk++; if (bus.Mem_Timeout !== 1'b0) $display("FAIL tmo_cleared got=%b exp=0", bus.Mem_Timeout); else n_pass++;
    endtask

    task automatic test_random();
        int burst = 0;
        logic st, br, bz;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(MAX - 2, MAX + 3);
            st = ($urandom_range(0, 99) < 45);
            br = ($urandom_range(0, 99) < 20);
            bz = (burst > 0) || ($urandom_range(0, 99) < 12);
            if (burst > 0) burst--;
            apply(st, br, bz);
            n_chk++; if (act_ctrl() !== exp_ctrl()) $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", c, act_ctrl(), exp_ctrl()); else n_pass++;
            n_chk++; if (bus.HCU_State !== exp_state()) $display("FAIL rnd_state cyc=%0d got=%b exp=%b", c, bus.HCU_State, exp_state()); else n_pass++;
            n_chk++; if (bus.Mem_Timeout !== m_tmo) $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", c, bus.Mem_Timeout, m_tmo); else n_pass++;
`ifdef HCU_PERF_CNT_EN
            n_chk++; if (perf_stall !== 32'(m_ps) || perf_flush !== 32'(m_pf) || perf_mw !== 32'(m_pm))
                $display("FAIL rnd_perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c, perf_stall, perf_flush, perf_mw, m_ps, m_pf, m_pm);
            else n_pass++;
`endif
            tick();
        end
        rst = 1'b0;
    endtask

`ifdef HCU_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        apply(0, 0, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            apply(1, 0, 0); tick();
            apply(0, 0, 0); tick();
        end
        apply(0, 1, 0); tick();
        for (int k = 0; k < 4; k++) begin
            apply(0, 0, 1); tick();
        end
        apply(0, 0, 0); tick();
        n_chk++; if (perf_stall !== 32'd2) $display("FAIL perf_stall got=%0d exp=2", perf_stall); else n_pass++;
        n_chk++; if (perf_flush !== 32'd1) $display("FAIL perf_flush got=%0d exp=1", perf_flush); else n_pass++;
        n_chk++; if (perf_mw !== 32'd4) $display("FAIL perf_memwait got=%0d exp=4", perf_mw); else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        apply(0, 0, 0);
        test_reset();
        test_load_use();
        test_branch_stall();
        test_mem_wait();
        test_timeout();
`ifdef HCU_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
